// File: rtl/fetch_queue.sv
// fetch_queue: instruction-byte fetch unit feeding the cpu_ooo decoder.
// Streams sequential bytes from the fetch PC into a circular byte FIFO.
// It presents the oldest WIDTH bytes as a window to the decoder.
// A redirect squashes any in-flight byte and restarts fetch.
// Optional build macro FETCH_QUEUE_STATS_EN adds two outputs:
// stall_cycles and flush_count.
module fetch_queue #(
   parameter int          DEPTH    = 8,
   parameter int          WIDTH    = 3,
   parameter logic [15:0] RESET_PC = 16'hFFFC
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [15:0]                  addr_i,
   input  logic [7:0]                   din_i,
   input  logic                         redirect,
   input  logic [15:0]                  redirect_pc,
   output logic [8*WIDTH-1:0]           win_data,
   output logic [$clog2(WIDTH+1)-1:0]   win_count,
   output logic [15:0]                  win_pc,
   input  logic [$clog2(WIDTH+1)-1:0]   consume,
`ifdef FETCH_QUEUE_STATS_EN
   output logic [15:0]                  stall_cycles,
   output logic [15:0]                  flush_count,
`endif
   output logic                         full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int NW = $clog2(DEPTH + 1);
   localparam int OW = NW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [15:0]   fetch_pc_q, fetch_pc_d;
   logic [15:0]   win_pc_q, win_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [NW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;

   logic [CW-1:0] pops;
   logic          push;
   logic          issue;
   logic [OW-1:0] occupancy;
   logic [OW-1:0] occ_after_pop;

   // Occupancy bookkeeping: bytes queued plus the one still returning from memory.
   always_comb begin
      if (count_q >= NW'(WIDTH)) begin
         win_count = CW'(WIDTH);
      end else begin
         win_count = CW'(count_q);
      end
      pops          = (consume > win_count) ? win_count : consume;
      push          = inflight_q && !redirect;
      occupancy     = OW'(count_q) + OW'(inflight_q);
      occ_after_pop = occupancy - OW'(pops);
      issue         = !redirect && (occ_after_pop < OW'(DEPTH));
      full          = (occupancy == OW'(DEPTH));
      addr_i        = fetch_pc_q;
      win_pc        = win_pc_q;
   end

   // Window read: oldest bytes first, with unfilled slots forced to zero.
   always_comb begin
      win_data = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (k < int'(win_count)) begin
            win_data[8*k +: 8] = mem_q[rd_ptr_q + PW'(k)];
         end
      end
   end

   // Next-state logic. A redirect overrides pop, push and issue.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      win_pc_d   = win_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      inflight_d = 1'b0;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         win_pc_d   = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         inflight_d = issue;
         if (issue) begin
            fetch_pc_d = fetch_pc_q + 16'd1;
         end
         rd_ptr_d = rd_ptr_q + PW'(pops);
         win_pc_d = win_pc_q + 16'(pops);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         count_d = count_q + NW'(push) - NW'(pops);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         win_pc_q   <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         win_pc_q   <= win_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

   // Byte storage. Contents are masked by win_count, so they need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

`ifdef FETCH_QUEUE_STATS_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   // Saturating counters for stall cycles and redirect cycles.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!issue && !redirect && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end
      if (redirect && (flush_count_q != 16'hFFFF)) begin
         flush_count_d = flush_count_q + 16'd1;
      end
      stall_cycles = stall_cycles_q;
      flush_count  = flush_count_q;
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end
`endif

endmodule
